// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module : muldiv_if
// Brief  : Request/result bundle between the execute stage and muldiv_unit.
// Rev    : 1.0  initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output flush, start, op, a, b,
        input  hi_o, lo_o, busy_o, done_o
    );

    modport slave (
        input  flush, start, op, a, b,
        output hi_o, lo_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO writes.
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    muldiv_if.slave   bus
);
    localparam int CW = (WIDTH > 8) ? $clog2(WIDTH) : 3;

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_ITER = 2'd2,
        S_DIV_FIX  = 2'd3
    } state_t;

    state_t               r_state, w_state_nx;
    logic [CW-1:0]        r_cnt, w_cnt_nx;
    logic [WIDTH-1:0]     r_hi, w_hi_nx;
    logic [WIDTH-1:0]     r_lo, w_lo_nx;
    logic                 r_busy, r_done, w_done_nx;
    logic [2*WIDTH-1:0]   r_mul_a, w_mul_a_nx;
    logic [2*WIDTH-1:0]   r_mul_b, w_mul_b_nx;
    logic [WIDTH-1:0]     r_quo, w_quo_nx;
    logic [WIDTH-1:0]     r_rem, w_rem_nx;
    logic [WIDTH-1:0]     r_dvs, w_dvs_nx;
    logic [WIDTH-1:0]     r_dividend, w_dividend_nx;
    logic                 r_q_neg, w_q_neg_nx;
    logic                 r_r_neg, w_r_neg_nx;
    logic                 r_dvz, w_dvz_nx;

    logic                 w_accept;
    logic                 w_signed_div;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;

    assign w_accept     = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_signed_div = (bus.op == c_op_div);
    assign w_abs_a      = (w_signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b      = (w_signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // Operands are pre-extended to 2*WIDTH, so one unsigned multiply serves both modes.
    assign w_product    = r_mul_a * r_mul_b;
    assign w_shift      = {r_rem, r_quo[WIDTH-1]};
    assign w_diff       = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_hi_nx       = r_hi;
        w_lo_nx       = r_lo;
        w_done_nx     = 1'b0;
        w_mul_a_nx    = r_mul_a;
        w_mul_b_nx    = r_mul_b;
        w_quo_nx      = r_quo;
        w_rem_nx      = r_rem;
        w_dvs_nx      = r_dvs;
        w_dividend_nx = r_dividend;
        w_q_neg_nx    = r_q_neg;
        w_r_neg_nx    = r_r_neg;
        w_dvz_nx      = r_dvz;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.op)
                        c_op_mult, c_op_multu: begin
                            w_mul_a_nx = {{WIDTH{(bus.op == c_op_mult) & bus.a[WIDTH-1]}}, bus.a};
                            w_mul_b_nx = {{WIDTH{(bus.op == c_op_mult) & bus.b[WIDTH-1]}}, bus.b};
                            w_cnt_nx   = CW'(MUL_CYCLES - 1);
                            w_state_nx = S_MUL_WAIT;
                        end
                        c_op_div, c_op_divu: begin
                            w_quo_nx      = w_abs_a;
                            w_rem_nx      = '0;
                            w_dvs_nx      = w_abs_b;
                            w_dividend_nx = bus.a;
                            w_q_neg_nx    = w_signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            w_r_neg_nx    = w_signed_div & bus.a[WIDTH-1];
                            w_dvz_nx      = (bus.b == '0);
                            w_cnt_nx      = CW'(WIDTH - 1);
                            w_state_nx    = S_DIV_ITER;
                        end
                        c_op_mthi: w_hi_nx = bus.a;
                        c_op_mtlo: w_lo_nx = bus.a;
                        default: ;
                    endcase
                end
            end
            S_MUL_WAIT: begin
                if (r_cnt == '0) begin
                    w_hi_nx    = w_product[2*WIDTH-1:WIDTH];
                    w_lo_nx    = w_product[WIDTH-1:0];
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_DIV_ITER: begin
                // Restoring step: keep the trial subtraction only when it did not borrow.
                if (!w_diff[WIDTH]) begin
                    w_rem_nx = w_diff[WIDTH-1:0];
                    w_quo_nx = {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem_nx = w_shift[WIDTH-1:0];
                    w_quo_nx = {r_quo[WIDTH-2:0], 1'b0};
                end
                if (r_cnt == '0) begin
                    w_state_nx = S_DIV_FIX;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_DIV_FIX: begin
                if (r_dvz) begin
                    w_hi_nx = r_dividend;
                    w_lo_nx = '1;
                end else begin
                    w_hi_nx = r_r_neg ? -r_rem : r_rem;
                    w_lo_nx = r_q_neg ? -r_quo : r_quo;
                end
                w_done_nx  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (bus.flush) begin
            w_state_nx = S_IDLE;
            w_hi_nx    = r_hi;
            w_lo_nx    = r_lo;
            w_done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dvz      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_hi       <= w_hi_nx;
            r_lo       <= w_lo_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= w_done_nx;
            r_mul_a    <= w_mul_a_nx;
            r_mul_b    <= w_mul_b_nx;
            r_quo      <= w_quo_nx;
            r_rem      <= w_rem_nx;
            r_dvs      <= w_dvs_nx;
            r_dividend <= w_dividend_nx;
            r_q_neg    <= w_q_neg_nx;
            r_r_neg    <= w_r_neg_nx;
            r_dvz      <= w_dvz_nx;
        end
    end

    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;
    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the execute stage. It takes one MULT/MULTU/DIV/DIVU/MTHI/MTLO request per start strobe and runs multi-cycle operations in the background. It drives `busy_o` so the execute stage raises its multi-cycle stall. Width and multiply latency are parametrised. Flush and divide-by-zero behaviour are fully defined.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_CYCLES`, 3: multiply latency in cycles, legal range 1..8.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock; asynchronous, active-low
- `flush`  in  1  exception flush; aborts any operation in flight
- `start`  in  1  request strobe, sampled at the rising edge
- `op`  in  3  request code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOP
- `a`  in  WIDTH  rs value (multiplicand / dividend / MTxx source)
- `b`  in  WIDTH  rt value (multiplier / divisor)
- `hi_o`  out  WIDTH  HI register
- `lo_o`  out  WIDTH  LO register
- `busy_o`  out  1  multi-cycle operation in flight
- `done_o`  out  1  one-cycle pulse in the cycle after HI/LO were written by a mul/div

## Operation
- States: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- Request acceptance:
  - A request is accepted only in IDLE with `start`=1 and `flush`=0.
  - `start` while busy is ignored; the execute stage holds the instruction until `busy_o` falls.
- MTHI / MTLO: `hi_o` or `lo_o` takes the value of `a` at the accepting edge. No busy, no `done_o`.
- MULT / MULTU:
  - Operands are latched at acceptance.
  - The full 2·WIDTH product is signed or unsigned respectively.
  - MUL_WAIT counts `MUL_CYCLES`. At the final edge, HI gets `product[2W-1:W]` and LO gets `product[W-1:0]`, then the unit returns to IDLE.
- DIV / DIVU:
  - At acceptance: latch the operand magnitudes (absolute values for DIV) and the result signs.
  - DIV_ITER: restoring radix-2, one quotient bit per cycle, `WIDTH` cycles.
  - DIV_FIX: one cycle to apply signs. The quotient is truncated toward zero; the remainder carries the sign of the dividend. LO gets the quotient, HI gets the remainder.
  - Divisor 0, either mode: HI=`a`, LO=all ones. Latency is unchanged.
  - DIV with `a`=most-negative and `b`=−1: LO=most-negative, HI=0.
- Flush:
  - In any state, the next edge returns to IDLE.
  - HI/LO keep their pre-operation values; `done_o` stays 0.
  - `flush` and `start` together: flush wins and the request is dropped.
- Reads: `hi_o` and `lo_o` are the register outputs. The execute stage stalls MFHI/MFLO while `busy_o`=1.

## Timing
- Reset (async, `rst_n`=0): `hi_o`=0, `lo_o`=0, `busy_o`=0, `done_o`=0, state IDLE, counters 0. Reset asserted mid-operation abandons it immediately.
- `busy_o` is registered:
  - It rises the cycle after the accepting edge.
  - It falls in the same cycle HI/LO show the new value, which is also the cycle `done_o` is high.
- Multiply: `busy_o` is high for `MUL_CYCLES` cycles. The result is visible `MUL_CYCLES` edges after the accepting edge.
- Divide: `busy_o` is high for `WIDTH`+1 cycles (`WIDTH` in DIV_ITER, 1 in DIV_FIX). The result is visible `WIDTH`+1 edges after acceptance.
- Back-to-back: a new `start` may be accepted in the cycle `done_o`=1, since the unit is IDLE.
- MTHI/MTLO: value visible the cycle after acceptance. Accepted back-to-back every cycle.

## Test plan
- Reset then MULT: `a`=0xFFFFFFFF, `b`=0x00000002, `MUL_CYCLES`=3 → `busy_o` high for 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done_o` pulses once.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE. Follow with MTLO `a`=0x12345678 the next cycle → LO=0x12345678, HI unchanged.
- DIV: `a`=0xFFFFFFF9 (−7), `b`=2 → 33 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → HI=0x00000007, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0xA, LO=0xB, start DIVU 100/3, pulse `flush` in busy cycle 10 → `busy_o`=0 next cycle, HI=0xA, LO=0xB, no `done_o`. A `start` issued mid-operation (before the flush) is ignored. `flush` together with `start` → nothing accepted.
- `rst_n` low in cycle 5 of a DIV → all outputs 0 immediately. After release, a MULTU 3×5 → HI=0, LO=0xF.
